alu_serial_ctrl: RTL and testbench

Bit-serial sequencer around one alu_1bit slice (AND/OR/XOR/ADD, op select S[1:0]). It accepts a WIDTH-bit operation through a start/busy/done handshake and runs the single slice once per cycle, LSB first. A carry register links the slice positions. It delivers a full-width result and carry-out. It sits between the datapath control FSM and the shared 1-bit slice, trading latency for area.

---
 rtl/alu_serial_ctrl.sv | 126 ++++++++++++
 tb/tb_alu_serial_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial sequencer around one shared alu_1bit slice.
// A WIDTH-bit op is accepted via start/busy/done and evaluated LSB first,
// one bit per cycle, with a carry register linking slice positions.
// Optional feature macro: OVF_DETECT_EN (adds signed-overflow output ovf).

// One-bit ALU slice: 00 AND, 01 OR, 10 XOR, 11 ADD (full adder).
module alu_1bit (
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [1:0] s,
  output logic       f,
  output logic       cout
);
  // Function select; cout is only meaningful for ADD.
  always_comb begin
    f    = 1'b0;
    cout = (a & b) | (cin & (a ^ b));
    case (s)
      2'b00: f = a & b;
      2'b01: f = a | b;
      2'b10: f = a ^ b;
      2'b11: f = a ^ b ^ cin;
      default: f = 1'b0;
    endcase
  end
endmodule

module alu_serial_ctrl #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
`ifdef OVF_DETECT_EN
  output logic             ovf,
`endif
  output logic             cout
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sa, sb, res_sr;
  logic [1:0]       op_r;
  logic             carry, carry_nx;
  logic [CNT_W-1:0] cnt;
  logic             slice_f, slice_cout;
  logic             accept, last;

  assign busy     = (state == RUN);
  assign done     = (state == DONE);
  assign accept   = start & ~busy;
  assign last     = (cnt == CNT_W'(WIDTH - 1));
  // Logic ops never propagate a carry, which also forces cout to 0.
  assign carry_nx = (op_r == 2'b11) ? slice_cout : 1'b0;

  alu_1bit u_slice (
    .a    (sa[0]),
    .b    (sb[0]),
    .cin  (carry),
    .s    (op_r),
    .f    (slice_f),
    .cout (slice_cout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state: DONE is not busy, so a start there chains straight into RUN.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand latch, serial shift/carry datapath and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa     <= '0;
      sb     <= '0;
      res_sr <= '0;
      op_r   <= 2'b00;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
`ifdef OVF_DETECT_EN
      ovf    <= 1'b0;
`endif
    end else if (accept) begin
      sa    <= a;
      sb    <= b;
      op_r  <= op;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (state == RUN) begin
      sa     <= sa >> 1;
      sb     <= sb >> 1;
      res_sr <= {slice_f, res_sr[WIDTH-1:1]};
      carry  <= carry_nx;
      cnt    <= last ? cnt : cnt + CNT_W'(1);
      if (last) begin
        result <= {slice_f, res_sr[WIDTH-1:1]};
        cout   <= carry_nx;
`ifdef OVF_DETECT_EN
        // carry still holds the carry into the MSB during the last bit.
        ovf    <= (op_r == 2'b11) & (carry ^ slice_cout);
`endif
      end
    end
  end
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl: directed cases with literal
// expectations plus randomized traffic against a behavioural model.
// Honours OVF_DETECT_EN when defined.
module tb_alu_serial_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, cout;
  logic [W-1:0] result;
`ifdef OVF_DETECT_EN
  logic         ovf;
`endif

  int total = 0, bad = 0;
  int cyc = 0;
  bit armed = 0;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
`ifdef OVF_DETECT_EN
    .ovf(ovf),
`endif
    .cout(cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: operation completes WIDTH edges after acceptance,
  // result computed with whole-word arithmetic.
  int           m_left = 0;
  bit           m_done = 0;
  logic [1:0]   m_op;
  logic [W-1:0] m_a, m_b, m_res = '0;
  logic         m_cout = 0, m_ovf = 0;

  always @(posedge clk) begin
    logic [W:0] sum;
    if (rst) begin
      m_left = 0; m_done = 0; m_res = '0; m_cout = 0; m_ovf = 0;
    end else begin
      m_done = 0;
      if (m_left == 0) begin
        if (start) begin
          m_op = op; m_a = a; m_b = b; m_left = W;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1;
          m_cout = 0; m_ovf = 0;
          case (m_op)
            2'b00: m_res = m_a & m_b;
            2'b01: m_res = m_a | m_b;
            2'b10: m_res = m_a ^ m_b;
            default: begin
              sum    = {1'b0, m_a} + {1'b0, m_b};
              m_res  = sum[W-1:0];
              m_cout = sum[W];
              m_ovf  = (m_a[W-1] == m_b[W-1]) && (sum[W-1] != m_a[W-1]);
            end
          endcase
        end
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      chk("busy",   busy,   m_left > 0);
      chk("done",   done,   m_done);
      chk("result", result, m_res);
      chk("cout",   cout,   m_cout);
`ifdef OVF_DETECT_EN
      chk("ovf",    ovf,    m_ovf);
`endif
    end
  end

  // Present a request for one edge; returns the edge count of acceptance.
  task automatic go(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, output int t);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    t = cyc;
    start = 1'b0;
  endtask

  // Wait (bounded) for done, leaving time at the negedge of the done cycle.
  task automatic wait_done(input string name, output int t);
    bit ok = 0;
    t = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin ok = 1; t = cyc; break; end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s done timeout actual=0 expected=1", name);
    end
  endtask

  initial begin
    int t0, t1, t2, t3;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    armed = 1;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_result", result, 8'h00);
    chk("reset_cout", cout, 0);
    repeat (20) @(posedge clk);
    #1;

    // ADD wrap and latency.
    go(2'b11, 8'hFF, 8'h01, t0);
    wait_done("add_wrap", t1);
    chk("add_wrap_result", result, 8'h00);
    chk("add_wrap_cout", cout, 1);
    chk("add_wrap_latency", t1 - t0, W);

    // Back-to-back logic ops, each start issued during the previous DONE.
    @(posedge clk); #1;
    go(2'b00, 8'hF0, 8'h3C, t0);
    wait_done("and", t1);
    chk("and_result", result, 8'h30);
    chk("and_cout", cout, 0);
    op = 2'b01; a = 8'hF0; b = 8'h3C; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("or", t2);
    chk("or_result", result, 8'hFC);
    chk("or_spacing", t2 - t1, W + 1);
    op = 2'b10; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("xor", t3);
    chk("xor_result", result, 8'hCC);
    chk("xor_spacing", t3 - t2, W + 1);

    // Start while busy is ignored; operand changes during RUN have no effect.
    @(posedge clk); #1;
    go(2'b11, 8'h12, 8'h34, t0);
    @(posedge clk); #1;
    op = 2'b00; a = 8'h00; b = 8'h00; start = 1'b1;
    @(posedge clk); #1 start = 1'b0; a = 8'h55; b = 8'hAA;
    wait_done("busy_ignore", t1);
    chk("busy_ignore_result", result, 8'h46);
    chk("busy_ignore_cout", cout, 0);
    repeat (W + 3) @(negedge clk);
    chk("busy_ignore_single_done", busy, 0);

    // Reset mid-run aborts with no done pulse.
    @(posedge clk); #1;
    go(2'b11, 8'h80, 8'h80, t0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_result", result, 8'h00);
    chk("abort_cout", cout, 0);
    repeat (15) @(posedge clk);
    #1;
    go(2'b11, 8'h80, 8'h80, t0);
    wait_done("fresh_add", t1);
    chk("fresh_add_result", result, 8'h00);
    chk("fresh_add_cout", cout, 1);
`ifdef OVF_DETECT_EN
    chk("fresh_add_ovf", ovf, 1);
    @(posedge clk); #1;
    go(2'b11, 8'h7F, 8'h01, t0);
    wait_done("ovf_pos", t1);
    chk("ovf_pos_result", result, 8'h80);
    chk("ovf_pos_ovf", ovf, 1);
    chk("ovf_pos_cout", cout, 0);
    @(posedge clk); #1;
    go(2'b11, 8'h05, 8'h03, t0);
    wait_done("ovf_none", t1);
    chk("ovf_none_ovf", ovf, 0);
    chk("ovf_none_result", result, 8'h08);
`endif

    // Randomized traffic; the per-cycle compare does the checking.
    @(posedge clk); #1;
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      op    = 2'($urandom_range(0, 3));
      a     = W'($urandom);
      b     = W'($urandom);
      rst   = ($urandom_range(0, 199) == 0);
      @(posedge clk); #1;
    end
    rst = 1'b0; start = 1'b0;
    repeat (W + 4) @(posedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
